// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between NUM_REQ requesters.
// Holds start through the run, forwards the result with a done pulse, and handles flush/withdraw.
module div_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DRAIN_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      signed_i,
  input  logic [32*NUM_REQ-1:0]   op1_i,
  input  logic [32*NUM_REQ-1:0]   op2_i,
  input  logic [NUM_REQ-1:0]      flush_i,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic [63:0]             result_o,
  output logic                    busy_o,
  output logic                    div_start_o,
  output logic                    div_annul_o,
  output logic                    div_signed_o,
  output logic [31:0]             div_op1_o,
  output logic [31:0]             div_op2_o,
  input  logic [63:0]             div_result_i,
  input  logic                    div_ready_i
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d, owner_q, owner_d;
  logic [CW-1:0]        drain_q, drain_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic [63:0]          result_q, result_d;
  logic                 busy_q, busy_d, start_q, start_d, annul_q, annul_d;
  logic                 signed_q, signed_d;
  logic [31:0]          op1_q, op1_d, op2_q, op2_d;

  logic [NUM_REQ-1:0][31:0] op1_a, op2_a;
  logic                 found, abort;
  logic [IW-1:0]        pick;
  logic [IW:0]          cand;

  assign op1_a = op1_i;
  assign op2_a = op2_i;
  assign abort = flush_i[owner_q] | ~req_i[owner_q];

  // First eligible requester at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!found && req_i[cand[IW-1:0]] && !flush_i[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    drain_d  = drain_q;
    grant_d  = grant_q;
    done_d   = '0;
    result_d = result_q;
    start_d  = start_q;
    annul_d  = 1'b0;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    case (state_q)
      IDLE: if (found) begin
        state_d        = RUN;
        owner_d        = pick;
        rr_d           = (pick == IW'(NUM_REQ-1)) ? '0 : pick + 1'b1;
        grant_d        = '0;
        grant_d[pick]  = 1'b1;
        start_d        = 1'b1;
        signed_d       = signed_i[pick];
        op1_d          = op1_a[pick];
        op2_d          = op2_a[pick];
      end
      RUN: if (abort || div_ready_i) begin
        // Abort beats a simultaneous ready: the result is dropped.
        state_d = DRAIN;
        drain_d = CW'(DRAIN_CYC - 1);
        grant_d = '0;
        start_d = 1'b0;
        if (abort) begin
          annul_d = 1'b1;
        end else begin
          result_d         = div_result_i;
          done_d[owner_q]  = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = IDLE;
        else               drain_d = drain_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      drain_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      drain_q  <= drain_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end

  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign result_o     = result_q;
  assign busy_o       = busy_q;
  assign div_start_o  = start_q;
  assign div_annul_o  = annul_q;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares the single multi-cycle iterative divider between NUM_REQ requesters, e.g. the EX stage and a secondary issue slot.
- Arbitrates requests round-robin, drives the divider's start, annul, signed and operand inputs, and holds start high until the divider reports ready.
- Captures the 64-bit {remainder, quotient} result and returns it to the owning requester with a one-cycle done pulse.
- Drops start to return the divider to its free state, and handles cancellation (flush) of an in-flight division.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
DRAIN_CYC, 2, cycles start is held low after completion or annul before the next grant

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
req_i  input  NUM_REQ  per-requester request, level, held until done or withdrawn
signed_i  input  NUM_REQ  per-requester signed-divide flag
op1_i  input  32*NUM_REQ  dividends, requester k in bits [32k+31:32k]
op2_i  input  32*NUM_REQ  divisors, same packing
flush_i  input  NUM_REQ  per-requester cancel
grant_o  output  NUM_REQ  one-hot owner of the divider, 0 when none
done_o  output  NUM_REQ  one-cycle result-valid pulse to the owner
result_o  output  64  {remainder[63:32], quotient[31:0]}, valid with done_o
busy_o  output  1  divider allocated (state != IDLE)
div_start_o  output  1  to divider start
div_annul_o  output  1  to divider annul
div_signed_o  output  1  to divider signed select
div_op1_o  output  32  to divider dividend
div_op2_o  output  32  to divider divisor
div_result_i  input  64  from divider result
div_ready_i  input  1  from divider ready

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr pointer=0, drain counter=0.
  - All outputs 0, including result_o and the div_* signals.
- All outputs are registered.
- Operand latch: on grant, the owner's signed, op1 and op2 are latched into div_signed_o/op1/op2. These hold constant through RUN, independent of later requester inputs. The divider samples its operands again at completion, so they must be stable.
- States IDLE, RUN, DRAIN.
- IDLE:
  - If any req_i[k]=1 with flush_i[k]=0: select the first such k scanning from the rr pointer upward, wrapping modulo NUM_REQ.
  - Next cycle: grant_o=onehot(k), div_start_o=1, operands latched, state=RUN, rr pointer = k+1 mod NUM_REQ.
  - Otherwise all div_* stay 0.
- RUN: div_start_o=1, grant_o held.
  - Abort (owner flush_i=1, or owner req_i=0): next cycle div_start_o=0, div_annul_o=1 for exactly one cycle, no done_o, grant_o=0, state=DRAIN.
  - Complete (div_ready_i=1, no abort): next cycle result_o=div_result_i, done_o[owner]=1 for one cycle, div_start_o=0, grant_o=0, state=DRAIN.
  - Abort and ready in the same cycle: abort wins, result discarded, result_o unchanged.
  - Divide-by-zero needs no special case: the divider returns 0 and it is forwarded as a normal result.
- DRAIN: div_start_o=0, div_annul_o=0 after its first cycle. Held for DRAIN_CYC cycles, then IDLE. This covers the divider's by-zero-to-end path and its stop handshake. No grant is issued during DRAIN.
- Latency: req high in IDLE -> start high 1 cycle later. div_ready_i high -> done_o 1 cycle later.
- Fairness: a requester that stays asserted is served within NUM_REQ grants.
- result_o keeps its last value between done pulses.
- Non-owner flush_i or req_i changes have no effect on the current operation. A requester in IDLE with flush_i=1 is not granted that cycle.
- done_o and grant_o are never asserted for a non-owner. At most one bit of each is set.
- Reset mid-RUN: all outputs go to 0 immediately. The divider must be reset by the same rst domain.

Test Plan:
- Req0 unsigned 100/7, divider model → grant_o=01, start held until ready; done_o=01 one cycle after ready; result_o={32'd2,32'd14}; start low 2 cycles, then IDLE.
- Req1 signed 0xFFFFFFF9 / 2 → result_o={32'hFFFFFFFF,32'hFFFFFFFD}; done_o=10.
- Req0 and req1 both held from reset, 4 ops → grant order 0,1,0,1; each done matches its own operands; no overlap in grant_o.
- Req0 granted, flush_i[0]=1 at RUN cycle 10 → div_annul_o=1 one cycle, start=0, no done_o; req1 pending is granted after DRAIN_CYC cycles and completes correctly (result 1000/10={0,100}).
- Divide by zero, req0 op2=0 → done_o=01 with result_o=0; divider back to free; next op 9/3 gives {0,3}.
- Flush and ready in the same cycle → no done_o; result_o retains its previous value. Async rst pulse mid-RUN → all outputs 0 with no clock edge.
